dt_distance_transform: RTL and testbench

- Chessboard (8-neighbour) distance transform engine for a 128x128 binary image.
- Reads the packed image from an external 1024x16 stimulus ROM and writes an 8-bit distance map into an external 16384x8 result RAM.
- Runs a forward raster pass, then a backward raster pass.
- Flags completion of each pass; sits between the image ROM and the result RAM as a self-contained accelerator.

---
 rtl/dt_pkg.sv | 49 ++++
 rtl/dt_min5.sv | 25 ++
 rtl/dt_distance_transform.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_dt_distance_transform.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared constants, FSM encoding and address helpers for the chessboard
// distance transform engine.
package dt_pkg;

  localparam int unsigned IMG_W         = 128;
  localparam int unsigned COORD_W       = 7;
  localparam int unsigned WORD_W        = 16;
  localparam int unsigned WORDS_PER_ROW = IMG_W / WORD_W;
  localparam int unsigned STI_ADDR_W    = 10;
  localparam int unsigned RES_ADDR_W    = 14;
  localparam int unsigned PIX_W         = 8;
  localparam int unsigned MIN_N         = 5;
  localparam int unsigned PERF_W        = 24;

  // Interior scan limits; rows/cols 0 and IMG_W-1 are the fixed zero border
  localparam logic [COORD_W-1:0] FIRST     = COORD_W'(1);
  localparam logic [COORD_W-1:0] LAST      = COORD_W'(IMG_W - 2);
  localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    FW_LOAD,
    FW_READ,
    FW_WRITE,
    FW_DONE,
    BW_READ,
    BW_WRITE,
    DONE
  } state_t;

  // ROM word holding pixel (row,col): row*8 + col/16
  function automatic logic [STI_ADDR_W-1:0] sti_addr_of(input logic [COORD_W-1:0] row,
                                                        input logic [COORD_W-1:0] col);
    return STI_ADDR_W'(row) * STI_ADDR_W'(WORDS_PER_ROW)
         + STI_ADDR_W'(col / COORD_W'(WORD_W));
  endfunction

  // RAM byte for pixel (row,col): row*128 + col
  function automatic logic [RES_ADDR_W-1:0] res_addr_of(input logic [COORD_W-1:0] row,
                                                        input logic [COORD_W-1:0] col);
    return RES_ADDR_W'(row) * RES_ADDR_W'(IMG_W) + RES_ADDR_W'(col);
  endfunction

  // Bit position of a pixel inside its ROM word (leftmost pixel in the MSB)
  function automatic logic [3:0] pix_bit(input logic [COORD_W-1:0] col);
    return 4'(WORD_W - 1) - 4'(col % COORD_W'(WORD_W));
  endfunction

endpackage

// File: rtl/dt_min5.sv
// Combinational minimum of up to five 8-bit operands, each optionally
// incremented by one before comparison.
module dt_min5
  import dt_pkg::*;
(
  input  logic [MIN_N-1:0][PIX_W-1:0] ops,
  input  logic [MIN_N-1:0]            inc,
  input  logic [MIN_N-1:0]            use_op,
  output logic [PIX_W-1:0]            min_val_c
);

  // Running minimum over the enabled operands
  always_comb begin
    logic [PIX_W-1:0] cand;
    cand      = '0;
    min_val_c = '1;
    for (int i = 0; i < int'(MIN_N); i++) begin
      cand = ops[i] + PIX_W'(inc[i]);
      if (use_op[i] && (cand < min_val_c)) begin
        min_val_c = cand;
      end
    end
  end

endmodule

// File: rtl/dt_distance_transform.sv
// Chessboard distance transform of a 128x128 binary image: a forward raster
// pass followed by a backward raster pass over the result RAM.
// Optional macro DT_PERF_CNT_EN adds the perf_cycles completion counter.
module dt_distance_transform
  import dt_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  output logic                  sti_rd,
  output logic [STI_ADDR_W-1:0] sti_addr,
  input  logic [WORD_W-1:0]     sti_di,
  output logic                  res_rd,
  output logic                  res_wr,
  output logic [RES_ADDR_W-1:0] res_addr,
  output logic [PIX_W-1:0]      res_do,
  input  logic [PIX_W-1:0]      res_di,
  output logic                  fwpass_finish,
  output logic                  done
`ifdef DT_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]     perf_cycles
`endif
);

  state_t state, state_n;

  logic [1:0]            step, step_n;
  logic [COORD_W-1:0]    row, row_n, col, col_n;
  logic [WORD_W-1:0]     word, word_n;
  logic [PIX_W-1:0]      r0, r0_n, r1, r1_n, r2, r2_n;
  logic [PIX_W-1:0]      west, west_n, east, east_n;

  logic                  sti_rd_n, res_rd_n, res_wr_n;
  logic [STI_ADDR_W-1:0] sti_addr_n;
  logic [RES_ADDR_W-1:0] res_addr_n;
  logic [PIX_W-1:0]      res_do_n;
  logic                  fwpass_finish_n, done_n;

  logic                  fw_enter, fw_pix, bw_adv;
  logic                  fw_last, bw_last;
  logic [COORD_W-1:0]    fw_row_nx, fw_col_nx, bw_row_nx, bw_col_nx;

  logic                           is_fw;
  logic [MIN_N-1:0][PIX_W-1:0]    min_ops;
  logic [MIN_N-1:0]               min_inc, min_use;
  logic [PIX_W-1:0]               min_val;

  // Scan-order successors for both passes
  assign fw_last   = (row == LAST) && (col == LAST);
  assign fw_row_nx = (col == LAST) ? row + COORD_ONE : row;
  assign fw_col_nx = (col == LAST) ? FIRST : col + COORD_ONE;
  assign bw_last   = (row == FIRST) && (col == FIRST);
  assign bw_row_nx = (col == FIRST) ? row - COORD_ONE : row;
  assign bw_col_nx = (col == FIRST) ? LAST : col - COORD_ONE;

  // Forward: NW,N,NE,W each +1.  Backward: self, S+1, SW+1, SE+1, E+1.
  assign is_fw      = (state == FW_READ);
  assign min_ops[0] = r0;
  assign min_ops[1] = r1;
  assign min_ops[2] = is_fw ? res_di : r2;
  assign min_ops[3] = is_fw ? west : res_di;
  assign min_ops[4] = east;
  assign min_inc    = {1'b1, 1'b1, 1'b1, 1'b1, is_fw};
  assign min_use    = {~is_fw, 1'b1, 1'b1, 1'b1, 1'b1};

  dt_min5 u_min5 (
    .ops       (min_ops),
    .inc       (min_inc),
    .use_op    (min_use),
    .min_val_c (min_val)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_n         = state;
    step_n          = step;
    row_n           = row;
    col_n           = col;
    word_n          = word;
    r0_n            = r0;
    r1_n            = r1;
    r2_n            = r2;
    west_n          = west;
    east_n          = east;
    sti_rd_n        = 1'b0;
    sti_addr_n      = sti_addr;
    res_rd_n        = 1'b0;
    res_wr_n        = 1'b0;
    res_addr_n      = res_addr;
    res_do_n        = res_do;
    fwpass_finish_n = 1'b0;
    done_n          = done;
    fw_enter        = 1'b0;
    fw_pix          = 1'b0;
    bw_adv          = 1'b0;

    unique case (state)
      IDLE: begin
        row_n      = FIRST;
        col_n      = FIRST;
        west_n     = '0;
        state_n    = FW_LOAD;
        sti_rd_n   = 1'b1;
        sti_addr_n = sti_addr_of(FIRST, FIRST);
      end
      FW_LOAD: begin
        word_n   = sti_di;
        fw_enter = 1'b1;
        fw_pix   = sti_di[pix_bit(col)];
      end
      FW_READ: begin
        unique case (step)
          2'd0: begin
            r0_n       = res_di;
            res_rd_n   = 1'b1;
            res_addr_n = res_addr_of(row - COORD_ONE, col);
            step_n     = 2'd1;
          end
          2'd1: begin
            r1_n       = res_di;
            res_rd_n   = 1'b1;
            res_addr_n = res_addr_of(row - COORD_ONE, col + COORD_ONE);
            step_n     = 2'd2;
          end
          default: begin
            state_n    = FW_WRITE;
            res_wr_n   = 1'b1;
            res_addr_n = res_addr_of(row, col);
            res_do_n   = min_val;
            west_n     = min_val;
          end
        endcase
      end
      FW_WRITE: begin
        if (fw_last) begin
          state_n         = FW_DONE;
          fwpass_finish_n = 1'b1;
        end else begin
          row_n = fw_row_nx;
          col_n = fw_col_nx;
          if (col == LAST) west_n = '0;
          if ((fw_col_nx == FIRST) || (fw_col_nx[3:0] == 4'd0)) begin
            state_n    = FW_LOAD;
            sti_rd_n   = 1'b1;
            sti_addr_n = sti_addr_of(fw_row_nx, fw_col_nx);
          end else begin
            fw_enter = 1'b1;
            fw_pix   = word[pix_bit(fw_col_nx)];
          end
        end
      end
      FW_DONE: begin
        row_n      = LAST;
        col_n      = LAST;
        east_n     = '0;
        state_n    = BW_READ;
        step_n     = 2'd0;
        res_rd_n   = 1'b1;
        res_addr_n = res_addr_of(LAST, LAST);
      end
      BW_READ: begin
        unique case (step)
          2'd0: begin
            r0_n = res_di;
            if (res_di == '0) begin
              east_n = '0;
              bw_adv = 1'b1;
            end else begin
              res_rd_n   = 1'b1;
              res_addr_n = res_addr_of(row + COORD_ONE, col);
              step_n     = 2'd1;
            end
          end
          2'd1: begin
            r1_n       = res_di;
            res_rd_n   = 1'b1;
            res_addr_n = res_addr_of(row + COORD_ONE, col - COORD_ONE);
            step_n     = 2'd2;
          end
          2'd2: begin
            r2_n       = res_di;
            res_rd_n   = 1'b1;
            res_addr_n = res_addr_of(row + COORD_ONE, col + COORD_ONE);
            step_n     = 2'd3;
          end
          default: begin
            state_n    = BW_WRITE;
            res_wr_n   = 1'b1;
            res_addr_n = res_addr_of(row, col);
            res_do_n   = min_val;
            east_n     = min_val;
          end
        endcase
      end
      BW_WRITE: begin
        bw_adv = 1'b1;
      end
      DONE: begin
        done_n = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Start a forward pixel at (row_n,col_n): background writes 0 at once
    if (fw_enter) begin
      if (fw_pix) begin
        state_n    = FW_READ;
        step_n     = 2'd0;
        res_rd_n   = 1'b1;
        res_addr_n = res_addr_of(row_n - COORD_ONE, col_n - COORD_ONE);
      end else begin
        state_n    = FW_WRITE;
        res_wr_n   = 1'b1;
        res_addr_n = res_addr_of(row_n, col_n);
        res_do_n   = '0;
        west_n     = '0;
      end
    end

    // Step to the next backward pixel, or finish after (1,1)
    if (bw_adv) begin
      if (bw_last) begin
        state_n = DONE;
        done_n  = 1'b1;
      end else begin
        row_n = bw_row_nx;
        col_n = bw_col_nx;
        if (col == FIRST) east_n = '0;
        state_n    = BW_READ;
        step_n     = 2'd0;
        res_rd_n   = 1'b1;
        res_addr_n = res_addr_of(bw_row_nx, bw_col_nx);
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      step          <= '0;
      row           <= '0;
      col           <= '0;
      word          <= '0;
      r0            <= '0;
      r1            <= '0;
      r2            <= '0;
      west          <= '0;
      east          <= '0;
      sti_rd        <= 1'b0;
      sti_addr      <= '0;
      res_rd        <= 1'b0;
      res_wr        <= 1'b0;
      res_addr      <= '0;
      res_do        <= '0;
      fwpass_finish <= 1'b0;
      done          <= 1'b0;
    end else begin
      step          <= step_n;
      row           <= row_n;
      col           <= col_n;
      word          <= word_n;
      r0            <= r0_n;
      r1            <= r1_n;
      r2            <= r2_n;
      west          <= west_n;
      east          <= east_n;
      sti_rd        <= sti_rd_n;
      sti_addr      <= sti_addr_n;
      res_rd        <= res_rd_n;
      res_wr        <= res_wr_n;
      res_addr      <= res_addr_n;
      res_do        <= res_do_n;
      fwpass_finish <= fwpass_finish_n;
      done          <= done_n;
    end
  end

`ifdef DT_PERF_CNT_EN
  // Cycle count from reset release until done, then held
  always_ff @(posedge clk) begin
    if (reset)      perf_cycles <= '0;
    else if (!done) perf_cycles <= perf_cycles + PERF_W'(1);
  end
`endif

endmodule

// File: tb/tb_dt_distance_transform.sv
// Self-checking bench for dt_distance_transform: ROM/RAM models, a scoreboard
// of expected RAM writes and whole-map checks after each pass.
module tb_dt_distance_transform;

  typedef struct packed {
    logic [13:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sti_rd;
  logic [9:0]  sti_addr;
  logic [15:0] sti_di;
  logic        res_rd, res_wr;
  logic [13:0] res_addr;
  logic [7:0]  res_do, res_di;
  logic        fwpass_finish, done;
`ifdef DT_PERF_CNT_EN
  logic [23:0] perf_cycles;
`endif

  always #5 clk = ~clk;

  dt_distance_transform dut (
    .clk           (clk),
    .reset         (reset),
    .sti_rd        (sti_rd),
    .sti_addr      (sti_addr),
    .sti_di        (sti_di),
    .res_rd        (res_rd),
    .res_wr        (res_wr),
    .res_addr      (res_addr),
    .res_do        (res_do),
    .res_di        (res_di),
    .fwpass_finish (fwpass_finish),
    .done          (done)
`ifdef DT_PERF_CNT_EN
    ,
    .perf_cycles   (perf_cycles)
`endif
  );

  logic [15:0] rom [1024] = '{default: 16'h0000};
  logic [7:0]  ram [16384] = '{default: 8'h00};

  always @(negedge clk) if (sti_rd) sti_di <= rom[sti_addr];
  always @(negedge clk) if (res_rd) res_di <= ram[res_addr];
  always @(posedge clk) if (res_wr) ram[res_addr] <= res_do;

  bit         img [128][128];
  logic [7:0] fwm [128][128];
  logic [7:0] fin [128][128];
  wr_t        exp_q [$];
  int         n_fw, n_tot, pop_cnt;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Scoreboard: every RAM write must be the next expected one
  always @(negedge clk) begin
    if (res_wr) begin
      wr_t g, e;
      g = '{res_addr, res_do};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected got addr=%0d data=%0d", g.a, g.d);
      end else begin
        e = exp_q.pop_front();
        pop_cnt++;
        if (g != e) begin
          errors++;
          $display("FAIL write_seq #%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                   pop_cnt, g.a, g.d, e.a, e.d);
        end
      end
    end
  end

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Distance to the nearest background pixel, by growing square rings
  function automatic int chess_dist(input int r, input int c);
    for (int d = 1; d < 128; d++)
      for (int dr = -d; dr <= d; dr++)
        for (int dc = -d; dc <= d; dc++) begin
          int rr = r + dr;
          int cc = c + dc;
          if ((dr == d || dr == -d || dc == d || dc == -d) &&
              rr >= 0 && rr < 128 && cc >= 0 && cc < 128 && !img[rr][cc])
            return d;
        end
    return 255;
  endfunction

  task automatic set_pix(input int r, input int c);
    logic [15:0] w;
    img[r][c] = 1'b1;
    w = rom[r * 8 + c / 16];
    w[15 - c % 16] = 1'b1;
    rom[r * 8 + c / 16] = w;
  endtask

  task automatic build_image();
    for (int r = 10; r <= 12; r++) for (int c = 10; c <= 12; c++) set_pix(r, c);
    set_pix(64, 64);
    for (int r = 30; r <= 50; r++) for (int c = 70; c <= 90; c++) set_pix(r, c);
    set_pix(1, 1);
    set_pix(1, 126);
    set_pix(126, 126);
    for (int r = 80; r <= 126; r++)
      for (int c = 1; c <= 126; c++)
        if ($urandom_range(0, 7) == 0) set_pix(r, c);
  endtask

  task automatic compute_model();
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 128; c++) begin
        fwm[r][c] = 8'd0;
        fin[r][c] = img[r][c] ? 8'(chess_dist(r, c)) : 8'd0;
      end
    for (int r = 1; r <= 126; r++)
      for (int c = 1; c <= 126; c++)
        if (img[r][c]) begin
          int m;
          m = min2(min2(fwm[r-1][c-1], fwm[r-1][c]), min2(fwm[r-1][c+1], fwm[r][c-1]));
          fwm[r][c] = 8'(m + 1);
        end
  endtask

  task automatic load_queue();
    exp_q.delete();
    pop_cnt = 0;
    for (int r = 1; r <= 126; r++)
      for (int c = 1; c <= 126; c++)
        exp_q.push_back('{14'(r * 128 + c), fwm[r][c]});
    n_fw = exp_q.size();
    for (int r = 126; r >= 1; r--)
      for (int c = 126; c >= 1; c--)
        if (fwm[r][c] != 8'd0) exp_q.push_back('{14'(r * 128 + c), fin[r][c]});
    n_tot = exp_q.size();
  endtask

  task automatic compare_map(input string name, input bit final_map);
    int bad = 0;
    int first = -1;
    logic [7:0] want;
    for (int a = 0; a < 16384; a++) begin
      want = final_map ? fin[a / 128][a % 128] : fwm[a / 128][a % 128];
      if (ram[a] != want) begin
        bad++;
        if (first < 0) first = a;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s mismatches=%0d first addr=%0d got=%0d want=%0d", name, bad, first,
               ram[first], final_map ? fin[first / 128][first % 128] : fwm[first / 128][first % 128]);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_sti_rd"}, sti_rd, 0);
    chk({tag, "_sti_addr"}, sti_addr, 0);
    chk({tag, "_res_rd"}, res_rd, 0);
    chk({tag, "_res_wr"}, res_wr, 0);
    chk({tag, "_res_addr"}, res_addr, 0);
    chk({tag, "_res_do"}, res_do, 0);
    chk({tag, "_fwpass_finish"}, fwpass_finish, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic wait_fw(input string tag);
    bit seen = 0;
    for (int i = 0; i < 60000 && !seen; i++) begin
      @(negedge clk);
      seen = fwpass_finish;
    end
    chk({tag, "_fw_finish_seen"}, seen, 1);
    if (seen) begin
      chk({tag, "_fw_writes_before_finish"}, pop_cnt, n_fw);
      compare_map({tag, "_fw_map"}, 1'b0);
      @(negedge clk);
      chk({tag, "_fw_finish_pulse"}, fwpass_finish, 0);
    end
  endtask

  logic [7:0] blk_fw  [9] = '{1, 1, 1, 1, 2, 1, 1, 2, 1};
  logic [7:0] blk_fin [9] = '{1, 1, 1, 1, 2, 1, 1, 1, 1};

  initial begin
    bit seen;
    int bad;
    build_image();
    compute_model();
    load_queue();

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b0;

    // Run 1: interrupted part-way through the backward pass
    wait_fw("run1");
    for (int k = 0; k < 9; k++)
      chk($sformatf("run1_fw_block_%0d", k), ram[(10 + k / 3) * 128 + 10 + k % 3], blk_fw[k]);
    chk("run1_fw_single_8256", ram[8256], 1);
    repeat (3000) @(posedge clk);
    #1;
    chk("run1_not_done_yet", done, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    load_queue();
    check_idle("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Run 2: full uninterrupted transform from scratch
    wait_fw("run2");
    seen = 0;
    for (int i = 0; i < 60000 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk("run2_done_seen", seen, 1);
    chk("run2_all_writes_before_done", pop_cnt, n_tot);
    chk("run2_queue_empty", exp_q.size(), 0);
    compare_map("run2_final_map", 1'b1);
    for (int k = 0; k < 9; k++)
      chk($sformatf("final_block_%0d", k), ram[(10 + k / 3) * 128 + 10 + k % 3], blk_fin[k]);
    chk("final_single_8256", ram[8256], 1);
    chk("final_corner_1_1", ram[129], 1);
    bad = 0;
    for (int r = 30; r <= 50; r++)
      for (int c = 70; c <= 90; c++)
        if (ram[r * 128 + c] != 8'(min2(min2(r - 29, c - 69), min2(51 - r, 91 - c)))) bad++;
    chk("final_square_closed_form_bad", bad, 0);
    bad = 0;
    for (int i = 0; i < 128; i++)
      if (ram[i] != 0 || ram[127 * 128 + i] != 0 || ram[i * 128] != 0 || ram[i * 128 + 127] != 0)
        bad++;
    chk("border_untouched_bad", bad, 0);

`ifdef DT_PERF_CNT_EN
    begin
      logic [23:0] p0;
      p0 = perf_cycles;
      chk("perf_nonzero", int'(p0 != 0), 1);
      chk("perf_below_1m", int'(p0 < 24'd1000000), 1);
      repeat (20) @(negedge clk);
      chk("perf_frozen", perf_cycles, p0);
    end
`endif

    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!done || res_rd || res_wr || sti_rd || fwpass_finish) bad++;
    end
    chk("done_hold_idle_bad", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
